// File: rtl/display_pkg.sv
// Shared segment definitions and the hex-to-15-segment decoder used by the display blocks.
// Bit order: [0]a [1]b [2]c [3]d [4]e [5]f [6]g1 [7]g2 [8]h [9]i [10]j [11]k [12]l [13]m [14]dp
package display_pkg;

  localparam int SEG_W = 15;

  typedef logic [SEG_W-1:0] seg_t;

  localparam seg_t SEG_BLANK = 15'h0000;

  function automatic seg_t hex_segment_decode(input logic [3:0] nib);
    seg_t seg;
    case (nib)
      4'h0:    seg = 15'h0C3F;
      4'h1:    seg = 15'h0406;
      4'h2:    seg = 15'h00DB;
      4'h3:    seg = 15'h008F;
      4'h4:    seg = 15'h00E6;
      4'h5:    seg = 15'h00ED;
      4'h6:    seg = 15'h00FD;
      4'h7:    seg = 15'h0007;
      4'h8:    seg = 15'h00FF;
      4'h9:    seg = 15'h00EF;
      4'hA:    seg = 15'h00F7;
      4'hB:    seg = 15'h128F;
      4'hC:    seg = 15'h0039;
      4'hD:    seg = 15'h120F;
      4'hE:    seg = 15'h0079;
      default: seg = 15'h0071;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/scan_display_driver_if.sv
// Datapath-to-display bundle for scan_display_driver.
// With DISPLAY_DIM_EN defined, a 4-bit brightness control is carried as well.
interface scan_display_driver_if #(
  parameter int DIGITS = 4
);
  import display_pkg::*;

  logic                  enable;
  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic [DIGITS-1:0]     blank;
  logic                  lz_en;
`ifdef DISPLAY_DIM_EN
  logic [3:0]            brightness;
`endif
  seg_t                  segment_pattern;
  logic [DIGITS-1:0]     digit_select;
  logic                  frame_done;

  modport master (
`ifdef DISPLAY_DIM_EN
    output brightness,
`endif
    output enable, load, value, blank, lz_en,
    input  segment_pattern, digit_select, frame_done
  );

  modport slave (
`ifdef DISPLAY_DIM_EN
    input  brightness,
`endif
    input  enable, load, value, blank, lz_en,
    output segment_pattern, digit_select, frame_done
  );

endinterface

// File: rtl/scan_prescaler.sv
// Digit-slot timer: holds each digit for SCAN_DIV cycles, steps idx through the digits,
// and pulses frame_done_o for one cycle after idx wraps back to digit 0.
module scan_prescaler #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 1000,
  localparam int CW      = $clog2(SCAN_DIV + 1),
  localparam int IW      = $clog2(DIGITS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable_i,
  output logic [IW-1:0] idx_o,
  output logic          frame_done_o
);

  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          frame_done_q, frame_done_d;

  always_comb begin
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    frame_done_d = 1'b0;
    if (!enable_i) begin
      // Disabled: park on digit 0 so a re-enable starts with a full slot.
      cnt_d = '0;
      idx_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d        = '0;
      idx_d        = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      frame_done_d = (idx_q == IDX_LAST);
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign idx_o        = idx_q;
  assign frame_done_o = frame_done_q;

endmodule

// File: rtl/scan_display_driver.sv
// Time-multiplexed 15-segment display driver with blanking and leading-zero suppression.
// Define DISPLAY_DIM_EN to add PWM dimming of the segments via the brightness input.
module scan_display_driver
  import display_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  scan_display_driver_if.slave bus
);

  localparam int IW    = $clog2(DIGITS + 1);
  localparam int NSLOT = 1 << IW;

  logic [IW-1:0]        idx;
  logic                 frame_done;

  logic [4*DIGITS-1:0]  shadow_q, shadow_d;
  seg_t                 seg_q, seg_d;
  logic [DIGITS-1:0]    sel_q, sel_d;

  logic [3:0]           nib [NSLOT];
  logic [NSLOT-1:0]     blank_slot;
  logic [NSLOT-1:0]     zero_from;
  logic [DIGITS-1:0]    onehot;
  logic                 suppressed;

  scan_prescaler #(
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV)
  ) u_prescaler (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable_i     (bus.enable),
    .idx_o        (idx),
    .frame_done_o (frame_done)
  );

  // Per-slot views padded to a power of two so idx can index them directly.
  for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slot
    if (gi < DIGITS) begin : g_real
      assign nib[gi]        = shadow_q[4*gi +: 4];
      assign blank_slot[gi] = bus.blank[gi];
      assign zero_from[gi]  = (shadow_q[4*DIGITS-1:4*gi] == '0);
    end else begin : g_pad
      assign nib[gi]        = 4'h0;
      assign blank_slot[gi] = 1'b1;
      assign zero_from[gi]  = 1'b1;
    end
  end

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_onehot
    assign onehot[gi] = (idx == IW'(gi));
  end

  assign suppressed = blank_slot[idx] | (bus.lz_en & (idx != '0) & zero_from[idx]);

`ifdef DISPLAY_DIM_EN
  logic [3:0] pwm_q, pwm_d;

  always_comb begin
    pwm_d = bus.enable ? pwm_q + 4'd1 : 4'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_q <= 4'd0;
    else        pwm_q <= pwm_d;
  end
`endif

  always_comb begin
    shadow_d = bus.load ? bus.value : shadow_q;
    sel_d    = '0;
    seg_d    = SEG_BLANK;
    if (bus.enable) begin
      sel_d = onehot;
      if (!suppressed) seg_d = hex_segment_decode(nib[idx]);
`ifdef DISPLAY_DIM_EN
      // pwm > brightness is the same test as pwm >= brightness+1 without the 5-bit sum.
      if (pwm_q > bus.brightness) seg_d = SEG_BLANK;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      seg_q    <= SEG_BLANK;
      sel_q    <= '0;
    end else begin
      shadow_q <= shadow_d;
      seg_q    <= seg_d;
      sel_q    <= sel_d;
    end
  end

  assign bus.segment_pattern = seg_q;
  assign bus.digit_select    = sel_q;
  assign bus.frame_done      = frame_done;

endmodule

// File: doc/scan_display_driver.md
Name: scan_display_driver

Overview:
- Time-multiplexed driver for a bank of DIGITS 15-segment displays.
- Latches a DIGITS×4-bit hex value on a load strobe and scans the digits one at a time.
- Decodes each digit to a 15-bit segment pattern, with per-digit blanking and leading-zero suppression.
- Sits between the datapath, which presents result values, and the board display pins; it is the sequential successor to the single-digit combinational display decoder.

Parameters:
- DIGITS, 4, number of multiplexed digits (1..8).
- SCAN_DIV, 1000, clock cycles each digit is held active (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  scan enable; 0 turns the display off.
- load  input  1  one-cycle strobe that captures value into the shadow register.
- value  input  4*DIGITS  hex nibbles; digit i is value[4i+3:4i], digit 0 is least significant.
- blank  input  DIGITS  per-digit forced blank, sampled live.
- lz_en  input  1  leading-zero suppression enable, sampled live.
- segment_pattern  output  15  active-high segment drive.
- digit_select  output  DIGITS  one-hot active-high digit enable.
- frame_done  output  1  one-cycle pulse on completion of a full scan.

Behaviour:
- Reset (rst_n low, asynchronous) clears:
  - shadow register to 0, prescaler cnt to 0, digit index idx to 0;
  - segment_pattern to 15'h0000, digit_select to all zero, frame_done to 0.
- Shadow register:
  - On each edge with load=1, shadow <= value. Otherwise it holds.
  - load is independent of enable; it is captured even while the display is off.
- Prescaler:
  - While enable=1, cnt increments by one per cycle.
  - At cnt==SCAN_DIV-1 a tick occurs: cnt <= 0 and idx <= (idx==DIGITS-1) ? 0 : idx+1.
  - With SCAN_DIV=1, a tick occurs every cycle.
- frame_done:
  - Registered; it is 1 for exactly the cycle after the edge on which idx wraps from DIGITS-1 to 0.
  - With DIGITS=1, it pulses on every tick.
- Output registers are updated every edge from the current idx and shadow, so outputs lag idx by exactly one cycle:
  - digit_select <= one-hot(idx);
  - segment_pattern <= suppressed ? 15'h0000 : hex_segment_decode(shadow digit idx).
- A digit is suppressed when:
  - blank[idx]=1; or
  - lz_en=1, idx>0, and shadow digits idx..DIGITS-1 are all zero. Digit 0 is never suppressed by lz_en.
- Load latency: load asserted at edge k → shadow updated at edge k → segment_pattern reflects the new value at edge k+1, if that digit is selected. There is no tearing handshake; a mid-scan load takes effect immediately on the current digit.
- enable=0:
  - cnt and idx are forced to 0; digit_select and segment_pattern are 0 from the next edge; frame_done is 0.
  - When enable is reasserted, scanning restarts at digit 0 with a full SCAN_DIV slot.
- Simultaneous load and tick: the shadow update and the idx advance both take effect on the same edge.
- Widths: cnt is $clog2(SCAN_DIV+1) bits and idx is $clog2(DIGITS+1) bits; neither ever holds a value outside its legal range.

Optional Feature:
- Macro: DISPLAY_DIM_EN.
- With the macro defined:
  - An extra input brightness [3:0] is added.
  - A 4-bit free-running pwm counter runs while enable=1 and is reset to 0 by rst_n or enable=0.
  - segment_pattern is forced to 15'h0000 on any cycle where pwm >= brightness+1.
  - brightness=15 gives full on; brightness=0 gives 1/16 duty.
  - digit_select is unaffected.
- Without the macro: the brightness port is absent, there is no pwm logic, and segments are always at full duty.

Decomposition:
- Shared package display_pkg holds:
  - SEG_W = 15;
  - SEG_BLANK = 15'h0000;
  - a typedef for a segment pattern;
  - a hex_segment_decode function (4-bit → 15-bit), reused by the bench as the reference model.
- One natural sub-module, scan_prescaler: cnt/idx/tick/frame_done generation, parameterised by DIGITS and SCAN_DIV.

Test Plan:
1. Reset: DIGITS=4, SCAN_DIV=4, hold rst_n=0 → segment_pattern=15'h0000, digit_select=4'b0000, frame_done=0; release mid-cycle → outputs are still 0 until enable=1.
2. Scan order: load value=16'h1234, enable=1 → digit_select steps 0001, 0010, 0100, 1000, each held 4 cycles; segments = decode(4), decode(3), decode(2), decode(1); frame_done pulses exactly once per 16 cycles.
3. Leading zeros: value=16'h0050, lz_en=1 → digits 3 and 2 give 15'h0000, digit 1 gives decode(5), digit 0 gives decode(0); with lz_en=0, digits 3 and 2 give decode(0).
4. Mid-scan load plus blank: during digit 2's slot, load 16'hFFFF and set blank=4'b0001 → digit 2 shows decode(F) one cycle after the load edge; digit 0 gives 15'h0000 on its next slot.
5. Enable drop: deassert enable during digit 1 → next edge all outputs 0; reassert → digit_select=0001 for a full 4 cycles.
6. DISPLAY_DIM_EN, brightness=3 → segment_pattern is non-zero on exactly 4 of every 16 cycles; brightness=15 → non-zero on every cycle.
